// File: rtl/fir_stream_pkg.sv
// Shared defaults and state encoding for the FIR stream feeder.
package fir_stream_pkg;

  localparam int unsigned DwDefault       = 18;
  localparam int unsigned DepthDefault    = 8;
  localparam int unsigned FlushLenDefault = 16;
  localparam int unsigned CntWDefault     = 16;

  typedef enum logic {
    StStream,
    StFlush
  } feeder_state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered pointers and an occupancy count; head is the oldest entry.
module stream_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fir_stream_feeder.sv
// Feeds buffered samples into a pipelined FIR and appends zero samples after each burst
// so the final result drains; the filter only advances on a real or flush sample.
module fir_stream_feeder
  import fir_stream_pkg::*;
#(
  parameter int unsigned DW        = DwDefault,
  parameter int unsigned DEPTH     = DepthDefault,
  parameter int unsigned FLUSH_LEN = FlushLenDefault,
  parameter int unsigned CNT_W     = CntWDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_last,
  input  logic                 m_ready,
  output logic                 fir_clk_ena,
  output logic                 fir_i_valid,
  output logic signed [DW-1:0] fir_i_in,
  output logic                 flushing,
  output logic                 flush_done,
  output logic [CNT_W-1:0]     samples_sent
);

  localparam int unsigned FcW = $clog2(FLUSH_LEN + 1);

  feeder_state_e  state_q, state_d;
  logic [FcW-1:0] flush_cnt_q, flush_cnt_d;
  logic           flush_done_q, flush_done_d;
  logic [CNT_W-1:0] samples_sent_q, samples_sent_d;

  logic [DW:0]    fifo_head;
  logic [DW-1:0]  head_data;
  logic           head_last;
  logic           fifo_full, fifo_empty;
  logic           push, pop;

  assign s_ready   = ~fifo_full;
  assign push      = s_valid & s_ready;
  assign pop       = (state_q == StStream) & fir_clk_ena;
  assign head_data = fifo_head[DW-1:0];
  assign head_last = fifo_head[DW];

  stream_fifo #(
    .WIDTH(DW + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata({s_last, s_data}),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    fir_clk_ena = 1'b0;
    fir_i_valid = 1'b0;
    fir_i_in    = '0;
    unique case (state_q)
      StStream: begin
        fir_clk_ena = m_ready & ~fifo_empty;
        fir_i_valid = ~fifo_empty;
        fir_i_in    = fifo_empty ? '0 : head_data;
      end
      StFlush: fir_clk_ena = m_ready;
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    flush_done_d   = 1'b0;
    samples_sent_d = samples_sent_q;
    unique case (state_q)
      StStream: begin
        if (pop) begin
          samples_sent_d = samples_sent_q + CNT_W'(1);
          if (head_last) begin
            state_d     = StFlush;
            flush_cnt_d = FcW'(FLUSH_LEN);
          end
        end
      end
      StFlush: begin
        // Counter only moves on enabled cycles, so a stall cannot shorten the flush.
        if (m_ready) begin
          flush_cnt_d = flush_cnt_q - FcW'(1);
          if (flush_cnt_q == FcW'(1)) begin
            state_d      = StStream;
            flush_done_d = 1'b1;
          end
        end
      end
      default: state_d = StStream;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StStream;
      flush_cnt_q    <= '0;
      flush_done_q   <= 1'b0;
      samples_sent_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      flush_done_q   <= flush_done_d;
      samples_sent_q <= samples_sent_d;
    end
  end

  assign flushing     = (state_q == StFlush);
  assign flush_done   = flush_done_q;
  assign samples_sent = samples_sent_q;

endmodule

// File: doc/fir_stream_feeder.md
Name: fir_stream_feeder

Overview:
Transmit-side front end for the pipelined symmetric FIR filters. Accepts samples from an upstream ready/valid stream and buffers them in a small FIFO. Drives the filter's clk_ena / i_valid / i_in input protocol so that tap history stays contiguous: the filter only advances when a real sample or a flush zero is presented. On an end-of-burst marker it injects FLUSH_LEN zero samples, so the last real sample's result drains out of the filter pipeline.

Parameters:
DW, 18, sample width; equals filter dw.
DEPTH, 8, FIFO depth in entries; power of 2, at least 2.
FLUSH_LEN, 16, zero samples injected after s_last; equals filter N_VALID_REGS.
CNT_W, 16, width of the sample counter.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream ready; equals !fifo_full
s_data  in  DW  upstream sample, signed
s_last  in  1  marks final sample of a burst
m_ready  in  1  downstream may advance; 0 stalls the filter
fir_clk_ena  out  1  to filter clk_ena
fir_i_valid  out  1  to filter i_valid
fir_i_in  out  DW  to filter i_in
flushing  out  1  high while in FLUSH state
flush_done  out  1  one-cycle pulse when flush completes
samples_sent  out  CNT_W  count of real samples delivered to the filter

Behaviour:
- Reset values:
  - FIFO empty; state STREAM; flush_cnt=0.
  - flush_done=0, samples_sent=0.
  - Hence s_ready=1, fir_clk_ena=0, fir_i_valid=0, fir_i_in=0.
- FIFO storage:
  - Each entry is {last, data}, DW+1 bits.
  - Push when s_valid & s_ready.
  - Push and pop in the same cycle are allowed, including when full: s_ready stays 0 while full; pop frees one entry the next cycle.
  - Pointers wrap modulo DEPTH. Full/empty derive from an occupancy count of log2(DEPTH)+1 bits.
- Output drive (combinational from registered state and FIFO head):
  - STREAM: fir_clk_ena = m_ready & !empty; fir_i_valid = !empty; fir_i_in = head.data when !empty, else 0.
  - FLUSH: fir_clk_ena = m_ready; fir_i_valid = 0; fir_i_in = 0.
  - Pop occurs iff state==STREAM & fir_clk_ena.
- State machine:
  - STREAM -> FLUSH when a popped entry has last=1. flush_cnt loads FLUSH_LEN on that edge.
  - FLUSH: flush_cnt decrements on each cycle with fir_clk_ena=1.
  - FLUSH -> STREAM on the enabled cycle where flush_cnt==1. flush_done=1 in the following cycle only.
  - Pushes continue during FLUSH; pops are suspended.
  - FLUSH_LEN=0 is illegal; it is not supported.
- Latency:
  - A sample pushed into an empty FIFO appears on fir_i_in in the next cycle.
  - It is consumed on the first subsequent cycle with m_ready=1.
- m_ready=0 freezes everything except FIFO pushes: no pop, no flush_cnt decrement, counter holds.
- samples_sent increments on every pop and wraps modulo 2^CNT_W.
- Back-to-back bursts: the last sample is followed by exactly FLUSH_LEN enabled zero cycles, then the next burst's first sample.
- Reset mid-operation: asynchronously returns to the reset values above. FIFO contents are discarded and any in-progress flush is abandoned.

Decomposition:
- Shared package fir_stream_pkg: DW default, FLUSH_LEN default, state enum {STREAM, FLUSH}.
- One sub-module, stream_fifo: synchronous FIFO with parameters WIDTH and DEPTH; outputs head, full, empty.
- FSM, flush counter and sample counter live in fir_stream_feeder.

Test Plan:
- Single burst: push 3 samples (5, -3, 7 with last) with m_ready=1.
  - fir_i_valid high for 3 enabled cycles carrying 5, -3, 7.
  - Then 16 enabled cycles with fir_i_valid=0 and fir_i_in=0.
  - flush_done pulses once; samples_sent=3.
- Backpressure: fill 8 entries with m_ready=0.
  - s_ready=0 after the 8th push; fir_clk_ena=0 throughout.
  - Raise m_ready: entries drain in order one per cycle; s_ready returns to 1 the cycle after the first pop.
- Stall during flush: deassert m_ready for 5 cycles mid-flush.
  - flush_cnt holds; exactly 16 enabled zero cycles are still issued.
  - flush_done is delayed by 5 cycles.
- Push during flush: send 2 samples while flushing=1.
  - Both are buffered; first appears on fir_i_in the cycle after the flush ends; no sample is lost or reordered.
- Empty FIFO gap: a 4-cycle upstream gap inside a burst produces fir_clk_ena=0 for those cycles, with no zero inserted into the filter.
- Reset mid-flush: assert reset with flush_cnt=9 and 3 entries queued.
  - All outputs return to reset values; s_ready=1; samples_sent=0.
  - A new burst after reset behaves as in the single-burst scenario.
